// File: rtl/ram_port_master.sv
// rtl/ram_port_master.sv - command-driven burst initiator for one dual-port RAM port
//
// Purpose:
//   Runs burst read, burst write and fill commands against one port of a RAM.
//   The RAM port is synchronous and samples on the falling edge of iClk.
//   Read data is returned through a 2-entry buffer to a valid/ready stream.
//
// Ports:
//   iClk, iRst                  clock (rising edge) and async active-high reset
//   iCmd*/oCmdReady             command channel (op, start address, length, fill pattern)
//   iWrValid/oWrReady/iWrData   write-data stream consumed by write bursts
//   oRdValid/iRdReady/oRdData   read-data stream produced by read bursts
//   oRamAddr/oRamEn/oRamWe/
//   oRamData/iRamData           RAM port
//   oBusy, oDone, oErr          status; oDone/oErr are one-cycle pulses
module ram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iCmdValid,
  output logic                  oCmdReady,
  input  logic [1:0]            iCmdOp,
  input  logic [ADDR_WIDTH-1:0] iCmdAddr,
  input  logic [LEN_WIDTH-1:0]  iCmdLen,
  input  logic [DATA_WIDTH-1:0] iCmdFillData,
  input  logic                  iWrValid,
  output logic                  oWrReady,
  input  logic [DATA_WIDTH-1:0] iWrData,
  output logic                  oRdValid,
  input  logic                  iRdReady,
  output logic [DATA_WIDTH-1:0] oRdData,
  output logic [ADDR_WIDTH-1:0] oRamAddr,
  output logic                  oRamEn,
  output logic                  oRamWe,
  output logic [DATA_WIDTH-1:0] oRamData,
  input  logic [DATA_WIDTH-1:0] iRamData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [1:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   fill_q, fill_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   buf_q [2];
  logic [DATA_WIDTH-1:0]   buf_d [2];
  logic                    head_q, head_d;
  logic [1:0]              count_q, count_d;

  logic                    cmd_ready;
  logic                    wr_ready;
  logic                    ram_en;
  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   ram_data;
  logic                    rd_issue;
  logic                    rd_pop;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    op_d     = op_q;
    fill_d   = fill_q;
    buf_d    = buf_q;
    head_d   = head_q;
    count_d  = count_q;
    wr_ready = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    // Without an access the data bus keeps showing the last word driven.
    ram_data = wdata_q;

    cmd_ready = (state_q == S_IDLE) && !iRst;

    // Read issue depends only on registered state so iRdReady never reaches
    // the RAM enable combinationally; a slot freed by a pop is reused next cycle.
    rd_issue = (state_q == S_READ) && (rem_q != '0) && (count_q != 2'd2);
    rd_pop   = (count_q != 2'd0) && iRdReady;

    // Tail slot is head + count (mod 2); never written when the buffer is full.
    if (rd_issue) begin
      buf_d[head_q ^ count_q[0]] = iRamData;
    end
    count_d = count_q + {1'b0, rd_issue} - {1'b0, rd_pop};
    if (rd_pop) begin
      head_d = ~head_q;
    end

    case (state_q)
      S_IDLE: begin
        if (iCmdValid && cmd_ready) begin
          addr_d = iCmdAddr;
          rem_d  = iCmdLen;
          op_d   = iCmdOp;
          fill_d = iCmdFillData;
          if (iCmdLen == '0) begin
            state_d = S_DONE;
          end else begin
            case (iCmdOp)
              OP_READ:  state_d = S_READ;
              OP_WRITE: state_d = S_WRITE;
              OP_FILL:  state_d = S_FILL;
              default:  state_d = S_DONE;
            endcase
          end
        end
      end
      S_READ: begin
        ram_en = rd_issue;
        if (rd_issue) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - LEN_ONE;
        end
        // Finish as soon as the last word leaves the buffer.
        if ((rem_d == '0) && (count_d == 2'd0)) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        wr_ready = (rem_q != '0);
        ram_en   = iWrValid && wr_ready;
        ram_we   = ram_en;
        if (ram_en) begin
          ram_data = iWrData;
          addr_d   = addr_q + ADDR_ONE;
          rem_d    = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_FILL: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_data = fill_q;
        addr_d   = addr_q + ADDR_ONE;
        rem_d    = rem_q - LEN_ONE;
        if (rem_q == LEN_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wdata_d = ram_data;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      op_q     <= OP_READ;
      fill_q   <= '0;
      wdata_q  <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      fill_q   <= fill_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      head_q   <= head_d;
      count_q  <= count_d;
    end
  end

  assign oCmdReady = cmd_ready;
  assign oWrReady  = wr_ready;
  assign oRamEn    = ram_en;
  assign oRamWe    = ram_we;
  assign oRamData  = ram_data;
  assign oRamAddr  = addr_q;
  assign oRdValid  = (count_q != 2'd0);
  assign oRdData   = buf_q[head_q];
  assign oBusy     = (state_q != S_IDLE);
  assign oDone     = (state_q == S_DONE);
  assign oErr      = (state_q == S_DONE) && (op_q == OP_RSVD);

endmodule
